// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared FSM state type and default geometry for the serial pattern generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PAT_W_DEF = 8;
  localparam int LEN_W_DEF = 4;

endpackage

// File: rtl/seq_gen_shift.sv
// seq_gen_shift: loadable MSB-first shift register with down-counting bit counter.
// Holds a copy of the aligned pattern so a frame can be reloaded for repetitions.
module seq_gen_shift
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             reload,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  output logic             bit_nxt,
  output logic             last
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  logic [PAT_W-1:0] pat_q, sr_q, sr_nxt, pat_aligned;
  logic [LEN_W-1:0] len_q, cnt_q, cnt_nxt, len_sat;

  // Left-align the used field so the first bit to send always sits in the MSB.
  always_comb begin
    len_sat     = (length > PAT_W_L) ? PAT_W_L : length;
    pat_aligned = pattern << (PAT_W_L - len_sat);
  end

  always_comb begin
    sr_nxt  = sr_q;
    cnt_nxt = cnt_q;
    if (load) begin
      sr_nxt  = pat_aligned;
      cnt_nxt = len_sat;
    end else if (reload) begin
      sr_nxt  = pat_q;
      cnt_nxt = len_q;
    end else if (shift) begin
      sr_nxt  = sr_q << 1;
      cnt_nxt = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q <= '0;
      len_q <= '0;
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (load) begin
        pat_q <= pat_aligned;
        len_q <= len_sat;
      end
      sr_q  <= sr_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign bit_nxt = sr_nxt[PAT_W-1];
  assign last    = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial frame generator with registered sequence_out/valid/busy/done.
// Build option SEQ_GEN_REPEAT_EN adds repeat_num: each frame is sent repeat_num+1 times.
// state | meaning
// IDLE  | waiting for start with nonzero length
// SHIFT | one frame bit per cycle on sequence_out
// DONE  | single-cycle done pulse, start ignored
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] length,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic [3:0]       repeat_num,
`endif
  output logic             sequence_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_t state_q, state_nxt;
  logic   load, shift, reload, bit_nxt, last;

`ifdef SEQ_GEN_REPEAT_EN
  logic [3:0] rep_q, rep_nxt;
`endif

  seq_gen_shift #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_shift (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .reload  (reload),
    .pattern (pattern),
    .length  (length),
    .bit_nxt (bit_nxt),
    .last    (last)
  );

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    shift     = 1'b0;
    reload    = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
    rep_nxt   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && (length != '0)) begin
          load      = 1'b1;
          state_nxt = SHIFT;
`ifdef SEQ_GEN_REPEAT_EN
          rep_nxt   = repeat_num;
`endif
        end
      end
      SHIFT: begin
        if (last) begin
`ifdef SEQ_GEN_REPEAT_EN
          if (rep_q != 4'd0) begin
            reload  = 1'b1;
            rep_nxt = rep_q - 4'd1;
          end else begin
            shift     = 1'b1;
            state_nxt = DONE;
          end
`else
          shift     = 1'b1;
          state_nxt = DONE;
`endif
        end else begin
          shift = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sequence_out <= 1'b0;
      valid        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      sequence_out <= (state_nxt == SHIFT) && bit_nxt;
      valid        <= (state_nxt == SHIFT);
      busy         <= (state_nxt == SHIFT);
      done         <= (state_nxt == DONE);
    end
  end

`ifdef SEQ_GEN_REPEAT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rep_q <= 4'd0;
    else        rep_q <= rep_nxt;
  end
`endif

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: randomized self-checking bench for seq_gen against a frame-level bit-queue model.
module tb_seq_gen;

`ifdef SEQ_GEN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] length = '0;
  logic [3:0] repeat_num = '0;
  logic       sequence_out, valid, busy, done;
  logic [3:0] det_hist = '0;

  int n_chk  = 0;
  int n_fail = 0;

  seq_gen #(.PAT_W(8), .LEN_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .pattern      (pattern),
    .length       (length),
`ifdef SEQ_GEN_REPEAT_EN
    .repeat_num   (repeat_num),
`endif
    .sequence_out (sequence_out),
    .valid        (valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_seq"},   32'(sequence_out), 32'd0);
    chk({tag, "_valid"}, 32'(valid),        32'd0);
    chk({tag, "_busy"},  32'(busy),         32'd0);
    chk({tag, "_done"},  32'(done),         32'd0);
  endtask

  // Expected stream: bits pattern[n-1]..pattern[0], n = min(len,8), repeated rep+1 times.
  task automatic send_frame(input logic [7:0] pat, input logic [3:0] len,
                            input logic [3:0] rep, input bit disturb);
    bit q[$];
    int n;
    n = (int'(len) > 8) ? 8 : int'(len);
    for (int r = 0; r <= int'(rep); r++)
      for (int i = n - 1; i >= 0; i--) q.push_back(pat[i]);
    @(negedge clock);
    pattern = pat; length = len; repeat_num = rep; start = 1'b1;
    @(negedge clock);
    foreach (q[k]) begin
      start = disturb;
      if (disturb) begin
        pattern    = 8'($urandom);
        length     = 4'($urandom_range(0, 15));
        repeat_num = 4'($urandom_range(0, 15));
      end
      chk("bit",   32'(sequence_out), 32'(q[k]));
      chk("valid", 32'(valid), 32'd1);
      chk("busy",  32'(busy),  32'd1);
      chk("done",  32'(done),  32'd0);
      det_hist = {det_hist[2:0], sequence_out};
      @(negedge clock);
    end
    chk("done_pulse", 32'(done),         32'd1);
    chk("done_valid", 32'(valid),        32'd0);
    chk("done_busy",  32'(busy),         32'd0);
    chk("done_seq",   32'(sequence_out), 32'd0);
    @(negedge clock);
    start = 1'b0;
    chk_idle("post_done");
  endtask

  initial begin
    logic [7:0] p;
    logic [3:0] l, r;
    #1;
    chk_idle("reset");
    @(negedge clock);
    reset = 1'b1;

    // Basic frame and loopback detector on the 1011 stream
    send_frame(8'b0000_1011, 4'd4, 4'd0, 1'b0);
    chk("detector_1011", 32'(det_hist == 4'b1011), 32'd1);

    // Zero length is ignored
    @(negedge clock);
    pattern = 8'hFF; length = 4'd0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk_idle("len0");
    end
    start = 1'b0;

    // Saturation and full width
    send_frame(8'b1100_1010, 4'd15, 4'd0, 1'b0);
    send_frame(8'b1010_0101, 4'd8,  4'd0, 1'b0);
    send_frame(8'b0000_0001, 4'd1,  4'd0, 1'b0);

    // Start re-asserted and inputs changed mid-frame
    send_frame(8'b0011_0110, 4'd6, 4'd0, 1'b1);

    // Reset during the second bit of a 6-bit frame
    @(negedge clock);
    pattern = 8'b0010_1101; length = 4'd6; repeat_num = 4'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("rst_first_bit", 32'(sequence_out), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_idle("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk_idle("rst_hold");
    end
    reset = 1'b1;
    send_frame(8'b0010_1101, 4'd6, 4'd0, 1'b0);

    if (REP_EN) send_frame(8'b0000_0101, 4'd3, 4'd2, 1'b0);

    for (int t = 0; t < 20; t++) begin
      p = 8'($urandom);
      l = 4'($urandom_range(1, 15));
      r = REP_EN ? 4'($urandom_range(0, 3)) : 4'd0;
      send_frame(p, l, r, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
